// File: rtl/counter_ctrl.sv
// Run/pause/step/clear sequencer for the 4-bit display counter.
// Debounces three active-low keys and drives the counter's enable/clear.
//
// Ports:
//   clock          system clock, all state on rising edge
//   reset          asynchronous active-low reset
//   key_start_n    raw key: start/resume or pause toggle
//   key_clear_n    raw key: clear counter and return to IDLE
//   key_step_n     raw key: single step when not running
//   mode_oneshot   1: stop in DONE once the counter reaches 4'hF
//   count          counter value, used for the one-shot terminal check
//   count_en       one-cycle increment pulse to the counter
//   count_clr      one-cycle synchronous clear pulse to the counter
//   running        1 while in RUN
//   state          IDLE=00 RUN=01 PAUSE=10 DONE=11
module counter_ctrl #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned DIV_W     = 26,
    parameter int unsigned DB_CYCLES = 500_000,
    parameter int unsigned DB_W      = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_start_n,
    input  logic       key_clear_n,
    input  logic       key_step_n,
    input  logic       mode_oneshot,
    input  logic [3:0] count,
    output logic       count_en,
    output logic       count_clr,
    output logic       running,
    output logic [1:0] state
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam int K_START = 0;
    localparam int K_CLEAR = 1;
    localparam int K_STEP  = 2;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [2:0] key_raw;
    assign key_raw = {key_step_n, key_clear_n, key_start_n};

    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    logic [2:0]      db_q;
    logic [2:0]      db_d;
    logic [2:0]      press_q;
    logic [2:0]      press_d;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             count_en_q;
    logic             count_en_d;
    logic             count_clr_q;
    logic             count_clr_d;
    logic             running_q;
    logic             running_d;

    // Debounce: the accepted level follows the synced level only after
    // it has disagreed for DB_CYCLES consecutive cycles. The press pulse
    // is registered so the FSM sees it one cycle after the level flips.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_d[i]     = db_q[i];
            press_d[i]  = 1'b0;
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i]    = sync2_q[i];
                    press_d[i] = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            db_q    <= '1;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            press_q <= press_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    logic do_clear;
    logic do_start;
    logic do_step;
    logic at_term;

    assign do_clear = press_q[K_CLEAR];
    assign do_start = press_q[K_START] & ~do_clear;
    assign do_step  = press_q[K_STEP] & ~do_clear & ~press_q[K_START];
    assign at_term  = mode_oneshot & (count == 4'hF);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        count_en_d  = 1'b0;
        count_clr_d = 1'b0;
        if (do_clear) begin
            state_d     = ST_IDLE;
            div_d       = '0;
            count_clr_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (do_start) begin
                        state_d = ST_RUN;
                        div_d   = '0;
                    end else if (do_step) begin
                        state_d    = ST_PAUSE;
                        count_en_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    // Pausing leaves the prescaler where it was.
                    if (do_start) begin
                        state_d = ST_PAUSE;
                    end else if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (at_term) begin
                            state_d = ST_DONE;
                        end else begin
                            count_en_d = 1'b1;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (do_start) begin
                        state_d = ST_RUN;
                    end else if (do_step) begin
                        if (at_term) begin
                            state_d = ST_DONE;
                        end else begin
                            count_en_d = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            count_en_q  <= count_en_d;
            count_clr_q <= count_clr_d;
            running_q   <= running_d;
        end
    end

    assign count_en  = count_en_q;
    assign count_clr = count_clr_q;
    assign running   = running_q;
    assign state     = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl with a behavioural reference model.
// Small TICK_DIV/DB_CYCLES so every path is reachable in a short run.
module tb_counter_ctrl;

    localparam int TD  = 4;
    localparam int DBC = 3;

    localparam int IDLE  = 0;
    localparam int RUN   = 1;
    localparam int PAUSE = 2;
    localparam int DONE  = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ks    = 1'b1;
    logic       kc    = 1'b1;
    logic       kp    = 1'b1;
    logic       mode  = 1'b0;
    logic [3:0] count = 4'h0;
    logic       count_en;
    logic       count_clr;
    logic       running;
    logic [1:0] state;

    always #5 clock = ~clock;

    counter_ctrl #(
        .TICK_DIV (TD),
        .DIV_W    (3),
        .DB_CYCLES(DBC),
        .DB_W     (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_start_n (ks),
        .key_clear_n (kc),
        .key_step_n  (kp),
        .mode_oneshot(mode),
        .count       (count),
        .count_en    (count_en),
        .count_clr   (count_clr),
        .running     (running),
        .state       (state)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Keys: a level is accepted once the last DBC synced samples all
    // disagree with the accepted level. Synced = raw seen two edges ago.
    int m_state;
    int m_div;
    int m_cnt;
    bit m_en;
    bit m_clr;
    bit m_s1    [3];
    bit m_s2    [3];
    bit m_db    [3];
    bit m_press [3];
    bit hist    [3][DBC];

    task automatic m_reset();
        m_state = IDLE;
        m_div   = 0;
        m_cnt   = 0;
        m_en    = 0;
        m_clr   = 0;
        for (int k = 0; k < 3; k++) begin
            m_s1[k]    = 1;
            m_s2[k]    = 1;
            m_db[k]    = 1;
            m_press[k] = 0;
            for (int j = 0; j < DBC; j++) hist[k][j] = 1;
        end
    endtask

    task automatic m_step();
        bit raw [3];
        bit np  [3];
        bit all_diff;
        bit clr_p;
        bit st_p;
        bit sp_p;
        bit term;
        bit ne;
        bit nc;
        int ns;
        raw[0] = ks;
        raw[1] = kc;
        raw[2] = kp;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < DBC - 1; j++) hist[k][j] = hist[k][j+1];
            hist[k][DBC-1] = m_s2[k];
            all_diff = 1;
            for (int j = 0; j < DBC; j++)
                if (hist[k][j] == m_db[k]) all_diff = 0;
            np[k] = 0;
            if (all_diff) begin
                m_db[k] = ~m_db[k];
                np[k]   = (m_db[k] == 0);
            end
            m_s2[k] = m_s1[k];
            m_s1[k] = raw[k];
        end
        clr_p = m_press[1];
        st_p  = m_press[0] && !clr_p;
        sp_p  = m_press[2] && !clr_p && !m_press[0];
        term  = mode && (m_cnt == 15);
        if (m_clr) m_cnt = 0;
        else if (m_en) m_cnt = (m_cnt + 1) % 16;
        ns = m_state;
        ne = 0;
        nc = 0;
        if (clr_p) begin
            ns    = IDLE;
            m_div = 0;
            nc    = 1;
        end else if (m_state == IDLE) begin
            if (st_p) begin
                ns    = RUN;
                m_div = 0;
            end else if (sp_p) begin
                ns = PAUSE;
                ne = 1;
            end
        end else if (m_state == RUN) begin
            if (st_p) ns = PAUSE;
            else if (m_div == TD - 1) begin
                m_div = 0;
                if (term) ns = DONE;
                else ne = 1;
            end else m_div++;
        end else if (m_state == PAUSE) begin
            if (st_p) ns = RUN;
            else if (sp_p) begin
                if (term) ns = DONE;
                else ne = 1;
            end
        end
        m_state = ns;
        m_en    = ne;
        m_clr   = nc;
        for (int k = 0; k < 3; k++) m_press[k] = np[k];
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) m_reset();
            else m_step();
        end
    end

    // Compare on every falling edge; also plays the role of counter_4.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                check("state", state, m_state);
                check("count_en", count_en, m_en);
                check("count_clr", count_clr, m_clr);
                check("running", running, (m_state == RUN));
                if (count_en && count_clr) check("en_clr_excl", 1, 0);
            end
            count = m_cnt[3:0];
        end
    end

    // ---------------- stimulus helpers ----------------
    int en_n;
    int clr_n;
    int run_entries;
    logic [1:0] prev_state = 2'b00;

    task automatic clr_counts();
        en_n        = 0;
        clr_n       = 0;
        run_entries = 0;
    endtask

    task automatic watch(int n);
        repeat (n) begin
            @(negedge clock);
            if (count_en) en_n++;
            if (count_clr) clr_n++;
            if (state == 2'b01 && prev_state != 2'b01) run_entries++;
            prev_state = state;
        end
    endtask

    task automatic set_key(int k, logic v);
        if (k == 0) ks = v;
        else if (k == 1) kc = v;
        else kp = v;
    endtask

    task automatic press(int k, int hold);
        set_key(k, 1'b0);
        watch(hold);
        set_key(k, 1'b1);
        watch(DBC + 5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int guard;
        clr_counts();
        repeat (3) @(negedge clock);
        check("reset_state", state, 0);
        check("reset_en", count_en, 0);
        check("reset_running", running, 0);
        #2 reset = 1'b1;

        // Idle after reset: nothing happens.
        clr_counts();
        watch(20);
        check("idle_state", state, 0);
        check("idle_en", en_n, 0);
        check("idle_clr", clr_n, 0);

        // Clean start press: RUN visible 2+3+1 edges after the press.
        ks = 1'b0;
        repeat (5) @(negedge clock);
        check("start_lat5", state, 0);
        @(negedge clock);
        check("start_lat6", state, 1);
        prev_state = state;
        ks = 1'b1;
        clr_counts();
        watch(16);
        check("en_rate", en_n, 4);

        // Pause, resume, pause again.
        press(0, 6);
        check("pause", state, 2);
        press(0, 6);
        check("resume", state, 1);
        press(0, 6);
        check("pause2", state, 2);

        // Three steps in PAUSE.
        clr_counts();
        repeat (3) press(2, 6);
        check("step_en", en_n, 3);
        check("step_state", state, 2);

        // Clear from PAUSE.
        clr_counts();
        press(1, 6);
        check("clear_pulse", clr_n, 1);
        check("clear_state", state, 0);

        // Bouncy start: one press, one RUN entry.
        clr_counts();
        ks = 1'b0; watch(1);
        ks = 1'b1; watch(1);
        ks = 1'b0; watch(12);
        ks = 1'b1; watch(8);
        check("bounce_entries", run_entries, 1);
        check("bounce_state", state, 1);

        // One-shot terminal stop.
        mode  = 1'b1;
        guard = 0;
        while (m_state != DONE && guard < 400) begin
            @(negedge clock);
            guard++;
        end
        check("oneshot_reached", (guard < 400), 1);
        check("done_state", state, 3);
        check("done_running", running, 0);
        clr_counts();
        press(0, 6);
        press(2, 6);
        check("done_hold", state, 3);
        check("done_no_en", en_n, 0);
        press(1, 6);
        check("done_clr", clr_n, 1);
        check("done_exit", state, 0);
        mode = 1'b0;

        // Clear and start in the same cycle: clear wins.
        clr_counts();
        ks = 1'b0;
        kc = 1'b0;
        watch(8);
        ks = 1'b1;
        kc = 1'b1;
        watch(8);
        check("cs_clr", clr_n, 1);
        check("cs_entries", run_entries, 0);
        check("cs_state", state, 0);

        // Random keys and mode against the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            if ($urandom_range(5, 0) == 0) ks = ~ks;
            if ($urandom_range(5, 0) == 0) kp = ~kp;
            if ($urandom_range(60, 0) == 0) kc = ~kc;
            else if (!kc && $urandom_range(3, 0) == 0) kc = 1'b1;
            if ($urandom_range(99, 0) == 0) mode = ~mode;
        end
        ks   = 1'b1;
        kc   = 1'b1;
        kp   = 1'b1;
        mode = 1'b0;
        watch(12);
        press(1, 6);
        check("rand_clear", state, 0);

        // Async reset in RUN while count_en is high.
        press(0, 6);
        guard = 0;
        while (!(m_state == RUN && m_en) && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("tick_seen", (guard < 50), 1);
        check("tick_en", count_en, 1);
        #1 reset = 1'b0;
        #1;
        check("async_en", count_en, 0);
        check("async_state", state, 0);
        check("async_running", running, 0);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        clr_counts();
        watch(10);
        check("post_reset_state", state, 0);
        check("post_reset_en", en_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
